// File: rtl/xintf_dpbram_arbiter.sv
// Shares one DPBRAM port between the asynchronous DSP XINTF bus and the waveform engine.
// XINTF strobes are synchronized and always win; idle slots are granted to the engine over req/gnt.
module xintf_dpbram_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int WR_SETTLE    = 3,
    parameter int WF_MAX_BURST = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_nZ_B_CS,
    input  logic              i_nZ_B_WE,
    input  logic [ADDR_W-1:0] i_Z_B_XA,
    input  logic [DATA_W-1:0] i_Z_B_XD,
    output logic [DATA_W-1:0] o_Z_B_XD,
    output logic              o_Z_B_XD_oe,
    input  logic              i_wf_req,
    input  logic              i_wf_we,
    input  logic [ADDR_W-1:0] i_wf_addr,
    input  logic [DATA_W-1:0] i_wf_din,
    output logic              o_wf_gnt,
    output logic [DATA_W-1:0] o_wf_dout,
    output logic              o_wf_rvalid,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic              o_bram_ce,
    output logic              o_bram_we,
    output logic [DATA_W-1:0] o_bram_din,
    input  logic [DATA_W-1:0] i_bram_dout,
    output logic [15:0]       o_wr_cnt,
    output logic              o_preempt
);

    localparam int SET_W = (WR_SETTLE > 1) ? $clog2(WR_SETTLE) : 1;
    localparam int BUR_W = $clog2(WF_MAX_BURST + 1);

    typedef enum logic [2:0] {
        IDLE, X_RD, X_WR_WAIT, X_WR_COMMIT, X_HOLD, WF
    } state_t;

    state_t              state, next_state;
    logic [SYNC_STAGES-1:0] cs_sync, we_sync;
    logic                cs_s, we_s;
    logic [SET_W-1:0]    set_cnt, set_cnt_d;
    logic [BUR_W-1:0]    bur_cnt, bur_cnt_d;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [15:0]         wr_cnt_q;
    logic                rd_v, oe_q, preempt_q, preempt_d, rvalid_q, latch_wr;
    logic [DATA_W-1:0]   xd_q;

    assign cs_s = cs_sync[SYNC_STAGES-1];
    assign we_s = we_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cs_sync   <= '1;
            we_sync   <= '1;
            state     <= IDLE;
            set_cnt   <= '0;
            bur_cnt   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_cnt_q  <= '0;
            rd_v      <= 1'b0;
            oe_q      <= 1'b0;
            xd_q      <= '0;
            preempt_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_nZ_B_CS};
            we_sync   <= {we_sync[SYNC_STAGES-2:0], i_nZ_B_WE};
            state     <= next_state;
            set_cnt   <= set_cnt_d;
            bur_cnt   <= bur_cnt_d;
            preempt_q <= preempt_d;
            rvalid_q  <= (state == WF) && i_wf_req && !i_wf_we;
            if (latch_wr) begin
                wr_addr_q <= i_Z_B_XA;
                wr_data_q <= i_Z_B_XD;
            end
            if (state == X_WR_COMMIT)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            // rd_v marks BRAM data from an X_RD access; oe follows it one cycle later with the pad register
            rd_v <= (state == X_RD) && !cs_s;
            oe_q <= rd_v && (state == X_RD) && !cs_s;
            if (rd_v)
                xd_q <= i_bram_dout;
        end
    end

    always_comb begin
        next_state  = state;
        set_cnt_d   = set_cnt;
        bur_cnt_d   = bur_cnt;
        latch_wr    = 1'b0;
        preempt_d   = 1'b0;
        o_bram_ce   = 1'b0;
        o_bram_we   = 1'b0;
        o_bram_addr = '0;
        o_bram_din  = '0;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    if (we_s) begin
                        next_state = X_RD;
                    end else begin
                        next_state = X_WR_WAIT;
                        set_cnt_d  = '0;
                    end
                end else if (i_wf_req) begin
                    next_state = WF;
                    bur_cnt_d  = '0;
                end
            end
            X_RD: begin
                o_bram_ce   = 1'b1;
                o_bram_addr = i_Z_B_XA;
                if (cs_s) next_state = IDLE;
            end
            X_WR_WAIT: begin
                if (cs_s || we_s) begin
                    next_state = IDLE;
                end else if (set_cnt == SET_W'(WR_SETTLE - 1)) begin
                    latch_wr   = 1'b1;
                    next_state = X_WR_COMMIT;
                end else begin
                    set_cnt_d = set_cnt + 1'b1;
                end
            end
            X_WR_COMMIT: begin
                o_bram_ce   = 1'b1;
                o_bram_we   = 1'b1;
                o_bram_addr = wr_addr_q;
                o_bram_din  = wr_data_q;
                next_state  = X_HOLD;
            end
            X_HOLD: begin
                if (cs_s) next_state = IDLE;
            end
            WF: begin
                if (i_wf_req) begin
                    o_bram_ce   = 1'b1;
                    o_bram_we   = i_wf_we;
                    o_bram_addr = i_wf_addr;
                    o_bram_din  = i_wf_din;
                    bur_cnt_d   = bur_cnt + 1'b1;
                end
                if (!cs_s) begin
                    preempt_d  = 1'b1;
                    next_state = IDLE;
                end else if (!i_wf_req || bur_cnt_d == BUR_W'(WF_MAX_BURST)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign o_wf_gnt    = (state == WF);
    assign o_wf_rvalid = rvalid_q;
    assign o_wf_dout   = rvalid_q ? i_bram_dout : '0;
    assign o_Z_B_XD    = xd_q;
    assign o_Z_B_XD_oe = oe_q && (state == X_RD) && !cs_s;
    assign o_wr_cnt    = wr_cnt_q;
    assign o_preempt   = preempt_q;

endmodule

// File: tb/tb_xintf_dpbram_arbiter.sv
// Bench for xintf_dpbram_arbiter: BRAM model plus write/read scoreboards checked at the falling edge.
module tb_xintf_dpbram_arbiter;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ncs, nwe;
    logic [AW-1:0] xa;
    logic [DW-1:0] xd_in, xd_out;
    logic          oe;
    logic          wf_req, wf_we, gnt, rvalid;
    logic [AW-1:0] wf_addr, bram_addr;
    logic [DW-1:0] wf_din, wf_dout, bram_din, bram_dout;
    logic          ce, we, preempt, mem_init;
    logic [15:0]   wr_cnt;

    always #5 clk = ~clk;

    xintf_dpbram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(2), .WR_SETTLE(3), .WF_MAX_BURST(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_nZ_B_CS(ncs), .i_nZ_B_WE(nwe), .i_Z_B_XA(xa), .i_Z_B_XD(xd_in),
        .o_Z_B_XD(xd_out), .o_Z_B_XD_oe(oe), .i_wf_req(wf_req), .i_wf_we(wf_we), .i_wf_addr(wf_addr),
        .i_wf_din(wf_din), .o_wf_gnt(gnt), .o_wf_dout(wf_dout), .o_wf_rvalid(rvalid),
        .o_bram_addr(bram_addr), .o_bram_ce(ce), .o_bram_we(we), .o_bram_din(bram_din),
        .i_bram_dout(bram_dout), .o_wr_cnt(wr_cnt), .o_preempt(preempt)
    );

    function automatic logic [DW-1:0] init_val(input int unsigned i);
        return (i == 32'h055) ? 16'hA5A5 : (DW'(i) * 16'h0101) ^ 16'h3C00;
    endfunction

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int unsigned i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
        end else if (ce) begin
            if (we) mem[bram_addr] <= bram_din;
            bram_dout <= mem[bram_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    logic [AW+DW-1:0] wr_q [$];
    logic [DW-1:0]    rd_q [$];
    int               preempt_cnt = 0;
    bit               prev_rd = 1'b0;

    // scoreboard: wf accesses push at grant, BRAM writes and rvalid pulses pop
    always @(negedge clk) begin
        if (rst) begin
            if (gnt && wf_req) begin
                chk("wf_ce_we", {30'd0, ce, we}, {30'd0, 1'b1, wf_we});
                chk("wf_addr", 32'(bram_addr), 32'(wf_addr));
                if (wf_we) begin
                    wr_q.push_back({wf_addr, wf_din});
                    ref_mem[wf_addr] = wf_din;
                end else begin
                    rd_q.push_back(ref_mem[wf_addr]);
                end
            end
            if (ce && we) begin
                if (wr_q.size() == 0) chk("unexpected_wr", 32'(wr_q.size()), 1);
                else chk("bram_wr", 32'({bram_addr, bram_din}), 32'(wr_q.pop_front()));
            end
            if (rvalid || prev_rd) begin
                chk("rvalid_lat", 32'(rvalid), 32'(prev_rd));
                if (rvalid && rd_q.size() > 0) chk("wf_dout", 32'(wf_dout), 32'(rd_q.pop_front()));
            end
            prev_rd = gnt && wf_req && !wf_we;
            if (preempt) preempt_cnt++;
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic x_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int ncyc, input bit commit);
        if (commit) begin
            wr_q.push_back({a, d});
            ref_mem[a] = d;
        end
        @(posedge clk); #1;
        xa = a; xd_in = d; ncs = 1'b0; nwe = 1'b0;
        repeat (ncyc) @(posedge clk);
        #1;
        ncs = 1'b1; nwe = 1'b1; xa = '0; xd_in = '0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic x_read(input logic [AW-1:0] a);
        int n = 0;
        @(posedge clk); #1;
        xa = a; ncs = 1'b0; nwe = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 7) ncs = 1'b1;
            @(negedge clk);
            if (oe) begin
                n++;
                chk("xrd_data", 32'(xd_out), 32'(ref_mem[a]));
            end
        end
        chk("xrd_oe_cycles", n, 5);
    endtask

    initial begin
        int run, gap, regrant, i, p0, pre_k, gnt_hold, oe_n, resumed, gnt_hi;
        bit g [0:21];
        rst = 1'b0; mem_init = 1'b1;
        ncs = 1'b1; nwe = 1'b1; xa = '0; xd_in = '0;
        wf_req = 1'b0; wf_we = 1'b0; wf_addr = '0; wf_din = '0;
        for (int unsigned j = 0; j < (1 << AW); j++) ref_mem[j] = init_val(j);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {26'd0, oe, gnt, ce, we, preempt, rvalid}, 0);
        chk("reset_wrcnt", 32'(wr_cnt), 0);
        chk("reset_xd", 32'(xd_out), 0);
        @(posedge clk); #1;
        rst = 1'b1; mem_init = 1'b0;
        repeat (2) @(posedge clk);

        // XINTF read of 0x055, CS low for 8 sampled cycles
        #1; xa = 9'h055; ncs = 1'b0; nwe = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 7) ncs = 1'b1;
            @(negedge clk);
            chk($sformatf("rd_oe_c%0d", k), 32'(oe), 32'(k >= 4 && k <= 8));
            if (k >= 4 && k <= 8) chk("rd_data", 32'(xd_out), 32'h0000A5A5);
        end
        repeat (3) @(posedge clk);

        // settled write, then a glitch that must not write
        x_write(9'h1FF, 16'h1234, 10, 1'b1);
        chk("wr_cnt_1", 32'(wr_cnt), 1);
        chk("wr_q_empty1", 32'(wr_q.size()), 0);
        x_read(9'h1FF);
        x_write(9'h0AA, 16'hDEAD, 2, 1'b0);
        chk("glitch_wr_cnt", 32'(wr_cnt), 1);
        x_read(9'h0AA);

        // waveform burst, req held high for 22 cycles
        @(posedge clk); #1;
        wf_req = 1'b1; wf_we = 1'b0; wf_addr = 9'h100;
        for (int k = 0; k < 22; k++) begin
            @(posedge clk); #1;
            wf_addr = 9'h100 + 9'(k + 1);
            @(negedge clk);
            g[k] = gnt;
        end
        @(posedge clk); #1; wf_req = 1'b0;
        i = 0; run = 0; gap = 0; regrant = 0;
        while (i < 22 && !g[i]) i++;
        while (i < 22 && g[i]) begin run++; i++; end
        while (i < 22 && !g[i]) begin gap++; i++; end
        if (i < 22) regrant = 1;
        chk("burst_len", run, 16);
        chk("burst_gap", 32'(gap >= 1), 1);
        chk("burst_regrant", regrant, 1);
        repeat (3) @(posedge clk);
        chk("rd_q_empty1", 32'(rd_q.size()), 0);

        // XINTF read preempts a mixed read/write burst
        p0 = preempt_cnt; pre_k = -1; gnt_hold = 0; oe_n = 0; resumed = 0;
        @(posedge clk); #1;
        wf_req = 1'b1; wf_we = 1'b0; wf_addr = 9'h180;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            wf_addr = 9'h180 + 9'(k);
            wf_we   = k[0];
            wf_din  = 16'(k * 3 + 16'h0700);
            if (k == 4) begin xa = 9'h055; ncs = 1'b0; nwe = 1'b1; end
            if (k == 14) ncs = 1'b1;
            @(negedge clk);
            if (preempt && pre_k < 0) begin
                pre_k = k;
                chk("preempt_gnt_low", 32'(gnt), 0);
            end
            if (pre_k >= 0 && k <= 16 && gnt) gnt_hold++;
            if (oe) begin
                oe_n++;
                chk("preempt_xrd_data", 32'(xd_out), 32'h0000A5A5);
            end
            if (k >= 17 && gnt) resumed = 1;
        end
        @(posedge clk); #1; wf_req = 1'b0; wf_we = 1'b0;
        chk("preempt_pulses", preempt_cnt - p0, 1);
        chk("preempt_hold_gnt", gnt_hold, 0);
        chk("preempt_xrd_seen", 32'(oe_n > 0), 1);
        chk("preempt_resume", resumed, 1);
        repeat (3) @(posedge clk);

        // counter wrap plus a CS/wf_req tie from IDLE
        force dut.wr_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.wr_cnt_q;
        @(negedge clk);
        chk("wrcnt_preset", 32'(wr_cnt), 32'h0000FFFF);
        p0 = preempt_cnt; gnt_hi = 0;
        wr_q.push_back({9'h0AA, 16'hBEEF});
        ref_mem[9'h0AA] = 16'hBEEF;
        @(posedge clk); #1;
        xa = 9'h0AA; xd_in = 16'hBEEF; ncs = 1'b0; nwe = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin wf_req = 1'b1; wf_we = 1'b0; wf_addr = 9'h010; end
            if (k == 9) begin ncs = 1'b1; nwe = 1'b1; end
            @(negedge clk);
            if (gnt) gnt_hi++;
        end
        chk("tie_no_gnt", gnt_hi, 0);
        for (int t = 0; t < 20 && !gnt; t++) @(negedge clk);
        chk("tie_regrant", 32'(gnt), 1);
        @(posedge clk); #1; wf_req = 1'b0;
        chk("wrcnt_wrap", 32'(wr_cnt), 0);
        chk("tie_wr_done", 32'(wr_q.size()), 0);
        chk("tie_no_preempt", preempt_cnt - p0, 0);
        repeat (3) @(posedge clk);
        x_read(9'h0AA);

        // reset during the settle window drops the write
        @(posedge clk); #1;
        xa = 9'h020; xd_in = 16'h7777; ncs = 1'b0; nwe = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {27'd0, oe, gnt, ce, we, preempt}, 0);
        chk("midrst_wrcnt", 32'(wr_cnt), 0);
        #1; ncs = 1'b1; nwe = 1'b1;
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        repeat (8) @(posedge clk);
        x_read(9'h020);
        chk("final_wr_q", 32'(wr_q.size()), 0);
        chk("final_rd_q", 32'(rd_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
